// File: rtl/router_pkg.sv
// Shared definitions for the router input port: flit type codes,
// framing FSM states and the default flit width.
package router_pkg;

  localparam int DEFAULT_DATA_WIDTH = 32;

  // Flit type lives in the top three bits of every flit.
  localparam logic [2:0] HEADER = 3'b001;
  localparam logic [2:0] BODY   = 3'b010;
  localparam logic [2:0] TAIL   = 3'b100;

  typedef enum logic {
    IDLE = 1'b0,
    PKT  = 1'b1
  } frame_state_t;

endpackage

// File: rtl/fifo_mem.sv
// DEPTH x DATA_WIDTH flit storage: one synchronous write port and one
// combinational read port. Contents are deliberately not reset.
module fifo_mem #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [DATA_WIDTH-1:0]    wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [DATA_WIDTH-1:0]    rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Store the accepted flit at the write pointer.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/router_input_fifo.sv
// Router input port buffer: CTS/DRTS handshake with the upstream arbiter,
// circular flit FIFO drained by five local grants, packet framing checker.
// Optional feature macro: PARITY_CHECK_EN (even parity in bit 0 of each flit).
//
// state | meaning
// IDLE  | between packets, next accepted flit must be a header
// PKT   | inside a packet, expecting body or tail flits
module router_input_fifo
  import router_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] RX,
  input  logic                  DRTS,
  output logic                  CTS,
  input  logic                  read_en_N,
  input  logic                  read_en_E,
  input  logic                  read_en_W,
  input  logic                  read_en_S,
  input  logic                  read_en_L,
  output logic [DATA_WIDTH-1:0] Data_out,
  output logic                  empty,
  output logic                  full,
  output logic                  protocol_err,
  output logic                  parity_err
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          read_en, wr_accept, rd_accept, frame_err;
  logic [2:0]    flit_type;
  frame_state_t  state_q, state_d;

  assign read_en   = read_en_N | read_en_E | read_en_W | read_en_S | read_en_L;
  // full is the registered view, so a read in the same cycle cannot open a slot early.
  assign wr_accept = DRTS & ~CTS & ~full;
  assign rd_accept = read_en & ~empty;
  assign flit_type = RX[DATA_WIDTH-1 -: 3];
  assign empty     = (count == '0);
  assign full      = (count == DEPTH_CNT);

  fifo_mem #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) u_mem (
    .clk   (clk),
    .we    (wr_accept),
    .waddr (wr_ptr),
    .wdata (RX),
    .raddr (rd_ptr),
    .rdata (Data_out)
  );

  // Handshake pulse, pointers and occupancy count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      CTS    <= 1'b0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      CTS <= wr_accept;
      if (wr_accept) wr_ptr <= wr_ptr + 1'b1;
      if (rd_accept) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_accept, rd_accept})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Framing state register and sticky violation flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      protocol_err <= 1'b0;
    end else begin
      state_q      <= state_d;
      protocol_err <= protocol_err | frame_err;
    end
  end

  // Framing next state; illegal types hold the state, a header inside a packet keeps PKT.
  always_comb begin
    state_d   = state_q;
    frame_err = 1'b0;
    if (wr_accept) begin
      case (state_q)
        IDLE: begin
          if (flit_type == HEADER) state_d = PKT;
          else                     frame_err = 1'b1;
        end
        PKT: begin
          if (flit_type == TAIL)      state_d = IDLE;
          else if (flit_type != BODY) frame_err = 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end
  end

`ifdef PARITY_CHECK_EN
  // One-cycle parity fault pulse; CTS blocks back-to-back accepts so it self-clears.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) parity_err <= 1'b0;
    else      parity_err <= wr_accept & (^RX);
  end
`else
  assign parity_err = 1'b0;
`endif

endmodule
